// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry and the write-back
// buffer state encoding.
package cpu_pkg;

   localparam int AW_DEFAULT = 5;
   localparam int DW_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FULL = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back entry storage: circular buffer of (address, data) pairs with
// wrapping pointers and an occupancy count. Entry ports exist only with REG_WRITEBACK_FORWARD_EN.
module wb_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = AW_DEFAULT,
   parameter int DW    = DW_DEFAULT,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [AW-1:0]    wr_addr,
   input  logic [DW-1:0]    wr_data,
   output logic [AW-1:0]    head_addr,
   output logic [DW-1:0]    head_data,
`ifdef REG_WRITEBACK_FORWARD_EN
   output logic [PTR_W-1:0] rd_ptr,
   output logic [AW-1:0]    ent_addr [DEPTH],
   output logic [DW-1:0]    ent_data [DEPTH],
`endif
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [AW-1:0]    addr_q [DEPTH];
   logic [AW-1:0]    addr_d [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DW-1:0]    data_d [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      addr_d   = addr_q;
      data_d   = data_q;
      if (push) begin
         addr_d[wr_ptr_q] = wr_addr;
         data_d[wr_ptr_q] = wr_data;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      // Power-of-two depth: pointer overflow is the modulo wrap.
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload needs no reset: the count alone decides which slots are live.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

   assign head_addr = (count_q != '0) ? addr_q[rd_ptr_q] : '0;
   assign head_data = (count_q != '0) ? data_q[rd_ptr_q] : '0;
   assign count     = count_q;

`ifdef REG_WRITEBACK_FORWARD_EN
   assign rd_ptr   = rd_ptr_q;
   assign ent_addr = addr_q;
   assign ent_data = data_q;
`endif

endmodule

// File: rtl/reg_writeback.sv
// Register write-back buffer: queues results, drains them into the register
// file around stalls, and optionally forwards pending data (REG_WRITEBACK_FORWARD_EN).
module reg_writeback
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = AW_DEFAULT,
   parameter int DW    = DW_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   RegWrite,
   input  logic [AW-1:0]          Write_register,
   input  logic [DW-1:0]          Write_data,
   output logic                   wb_ready,
   input  logic                   rf_stall,
   output logic                   rf_we,
   output logic [AW-1:0]          rf_waddr,
   output logic [DW-1:0]          rf_wdata,
   input  logic [AW-1:0]          lookup_reg,
   output logic                   lookup_hit,
   output logic [DW-1:0]          lookup_data,
   output logic [$clog2(DEPTH):0] pending
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   wb_state_t        state_q, state_d;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] count;
   logic [AW-1:0]    head_addr;
   logic [DW-1:0]    head_data;

`ifdef REG_WRITEBACK_FORWARD_EN
   logic [PTR_W-1:0] rd_ptr;
   logic [AW-1:0]    ent_addr [DEPTH];
   logic [DW-1:0]    ent_data [DEPTH];
   logic [PTR_W-1:0] idx;
`endif

   // Register 0 is hardwired zero: the handshake completes but nothing is stored.
   assign wb_ready = !reset && (count < FULL_CNT);
   assign push     = RegWrite && wb_ready && (Write_register != '0);
   assign rf_we    = !reset && (count != '0) && !rf_stall;
   assign pop      = rf_we;
   assign rf_waddr = head_addr;
   assign rf_wdata = head_data;
   assign pending  = count;

   wb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .wr_addr   (Write_register),
      .wr_data   (Write_data),
      .head_addr (head_addr),
      .head_data (head_data),
`ifdef REG_WRITEBACK_FORWARD_EN
      .rd_ptr    (rd_ptr),
      .ent_addr  (ent_addr),
      .ent_data  (ent_data),
`endif
      .count     (count)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (push) state_d = BUSY;
         BUSY: begin
            if (push && !pop && (count == FULL_CNT - CNT_W'(1))) begin
               state_d = FULL;
            end else if (pop && !push && (count == CNT_W'(1))) begin
               state_d = IDLE;
            end
         end
         FULL: if (pop) state_d = BUSY;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef REG_WRITEBACK_FORWARD_EN
   // Scan oldest to youngest so the last match wins.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      idx         = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count) && (lookup_reg != '0) && (ent_addr[idx] == lookup_reg)) begin
            lookup_hit  = 1'b1;
            lookup_data = ent_data[idx];
         end
      end
   end
`else
   logic unused_lookup;
   assign unused_lookup = ^lookup_reg;
   assign lookup_hit    = 1'b0;
   assign lookup_data   = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: table-driven single-cycle vectors plus
// hand-written fill, forwarding and reset-mid-drain sequences.
module tb_reg_writeback;
   import cpu_pkg::*;

   logic        clk;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  Write_register;
   logic [31:0] Write_data;
   logic        wb_ready;
   logic        rf_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  lookup_reg;
   logic        lookup_hit;
   logic [31:0] lookup_data;
   logic [2:0]  pending;

   int errors = 0;
   int checks = 0;

   reg_writeback #(.DEPTH(4), .AW(5), .DW(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .RegWrite       (RegWrite),
      .Write_register (Write_register),
      .Write_data     (Write_data),
      .wb_ready       (wb_ready),
      .rf_stall       (rf_stall),
      .rf_we          (rf_we),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata),
      .lookup_reg     (lookup_reg),
      .lookup_hit     (lookup_hit),
      .lookup_data    (lookup_data),
      .pending        (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic        stall;
      logic        exp_we;
      logic [4:0]  exp_waddr;
      logic [31:0] exp_wdata;
      logic [2:0]  exp_pend;
      logic        exp_ready;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // single write, pending=2 push+pop across pointer wrap, register 0
      tbl[0]  = '{1'b1, 5'd3, 32'h0000000F, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0, 1'b1};
      tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd3, 32'hF,  3'd1, 1'b1};
      tbl[2]  = '{1'b1, 5'd5, 32'hA5,       1'b1, 1'b0, 5'd0, 32'h0,  3'd0, 1'b1};
      tbl[3]  = '{1'b1, 5'd6, 32'hA6,       1'b1, 1'b0, 5'd5, 32'hA5, 3'd1, 1'b1};
      tbl[4]  = '{1'b1, 5'd7, 32'hA7,       1'b0, 1'b1, 5'd5, 32'hA5, 3'd2, 1'b1};
      tbl[5]  = '{1'b1, 5'd8, 32'hA8,       1'b0, 1'b1, 5'd6, 32'hA6, 3'd2, 1'b1};
      tbl[6]  = '{1'b1, 5'd9, 32'hA9,       1'b0, 1'b1, 5'd7, 32'hA7, 3'd2, 1'b1};
      tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd8, 32'hA8, 3'd2, 1'b1};
      tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd9, 32'hA9, 3'd1, 1'b1};
      tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,  3'd0, 1'b1};
      tbl[10] = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0, 1'b1};
      tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,  3'd0, 1'b1};

      reset = 1'b1;
      RegWrite = 1'b0;
      Write_register = '0;
      Write_data = '0;
      rf_stall = 1'b0;
      lookup_reg = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset rf_we", rf_we, 0);
      chk("reset wb_ready", wb_ready, 0);
      chk("reset pending", pending, 0);
      chk("reset rf_waddr", rf_waddr, 0);
      chk("reset rf_wdata", rf_wdata, 0);
      chk("reset lookup_hit", lookup_hit, 0);
      chk("reset state", dut.state_q, IDLE);
      reset = 1'b0;
      #1;
      chk("ready after reset", wb_ready, 1);
      tick();

      for (int i = 0; i < 12; i++) begin
         RegWrite = tbl[i].rw;
         Write_register = tbl[i].wreg;
         Write_data = tbl[i].wdata;
         rf_stall = tbl[i].stall;
         #1;
         chk($sformatf("v%0d rf_we", i), rf_we, tbl[i].exp_we);
         chk($sformatf("v%0d rf_waddr", i), rf_waddr, tbl[i].exp_waddr);
         chk($sformatf("v%0d rf_wdata", i), rf_wdata, tbl[i].exp_wdata);
         chk($sformatf("v%0d pending", i), pending, tbl[i].exp_pend);
         chk($sformatf("v%0d wb_ready", i), wb_ready, tbl[i].exp_ready);
         tick();
      end

      // Fill while stalled: five offered, four accepted.
      rf_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         RegWrite = 1'b1;
         Write_register = 5'(10 + i);
         Write_data = 32'h100 + 32'(i);
         #1;
         chk($sformatf("fill%0d wb_ready", i), wb_ready, (i < 4) ? 1 : 0);
         chk($sformatf("fill%0d rf_we", i), rf_we, 0);
         tick();
      end
      RegWrite = 1'b0;
      #1;
      chk("full pending", pending, 4);
      chk("full state", dut.state_q, FULL);
      chk("full wb_ready", wb_ready, 0);
      rf_stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("drain%0d rf_we", k), rf_we, 1);
         chk($sformatf("drain%0d rf_waddr", k), rf_waddr, 10 + k);
         chk($sformatf("drain%0d rf_wdata", k), rf_wdata, 32'h100 + 32'(k));
         if (k == 1) chk("drain state busy", dut.state_q, BUSY);
         tick();
      end
      chk("drained rf_we", rf_we, 0);
      chk("drained pending", pending, 0);
      chk("drained state", dut.state_q, IDLE);

      // Forwarding: youngest matching entry wins.
      rf_stall = 1'b1;
      RegWrite = 1'b1;
      Write_register = 5'd25;
      Write_data = 32'h1;
      tick();
      Write_data = 32'h2;
      tick();
      Write_register = 5'd24;
      Write_data = 32'h3;
      tick();
      RegWrite = 1'b0;
      lookup_reg = 5'd25;
      #1;
      chk("fwd pending", pending, 3);
`ifdef REG_WRITEBACK_FORWARD_EN
      chk("fwd25 hit", lookup_hit, 1);
      chk("fwd25 data", lookup_data, 32'h2);
`else
      chk("fwd25 hit", lookup_hit, 0);
      chk("fwd25 data", lookup_data, 0);
`endif
      lookup_reg = 5'd24;
      #1;
`ifdef REG_WRITEBACK_FORWARD_EN
      chk("fwd24 hit", lookup_hit, 1);
      chk("fwd24 data", lookup_data, 32'h3);
`else
      chk("fwd24 hit", lookup_hit, 0);
      chk("fwd24 data", lookup_data, 0);
`endif
      lookup_reg = 5'd0;
      #1;
      chk("fwd0 hit", lookup_hit, 0);
      lookup_reg = 5'd7;
      #1;
      chk("fwd7 hit", lookup_hit, 0);

      // Reset mid-drain with three entries pending.
      rf_stall = 1'b0;
      #1;
      chk("predrain rf_we", rf_we, 1);
      chk("predrain rf_waddr", rf_waddr, 25);
      chk("predrain rf_wdata", rf_wdata, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset rf_we", rf_we, 0);
      chk("async reset pending", pending, 0);
      chk("async reset wb_ready", wb_ready, 0);
      chk("async reset rf_waddr", rf_waddr, 0);
      chk("async reset lookup_data", lookup_data, 0);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk($sformatf("in reset%0d rf_we", k), rf_we, 0);
      end
      reset = 1'b0;
      #1;
      chk("post reset wb_ready", wb_ready, 1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("post reset%0d rf_we", k), rf_we, 0);
         chk($sformatf("post reset%0d pending", k), pending, 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
